digit_entry: RTL and testbench
==============================

Name: digit_entry

Overview:
- Input-side counterpart of the calculator's 4-digit multiplexed display driver.
- Conditions raw pushbuttons (synchronise, debounce, edge-detect) and runs the entry state machine.
- Holds a 4-digit BCD working value and a saved memory value.
- Drives the display driver's mode, digit-select and four active-low segment-pattern inputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (benches override to 4)

Ports:
clk  input  1  system clock; sole clock
rst  input  1  reset, asynchronous, active-high
btn_edit  input  1  raw button: enter edit / commit edit
btn_mem  input  1  raw button: show memory / cancel edit
btn_sel  input  1  raw button: advance selected digit
btn_inc  input  1  raw button: increment selected digit
btn_dec  input  1  raw button: decrement selected digit
mode  output  2  0=NORMAL, 1=EDIT (display blinks selected digit), 2=MEMORY
digit  output  2  selected digit index, 0 = rightmost
value  output  16  working value, BCD, [3:0]=digit0
mem_value  output  16  saved value, BCD
commit  output  1  one-cycle pulse when an edit is committed
digit0_display..digit3_display  output  8 each  active-low segments; bit0=a..bit6=g, bit7=dp (always 1)

Behaviour:
- Reset: asynchronous on rst=1; all state clears immediately, with no clk edge needed.
  - Reset values: mode=0, digit=0, value=0, mem_value=0, commit=0, debounced levels=0, debounce counters=0, all digitN_display=8'hC0.
  - Reset mid-edit discards the edit with no commit.
- Button conditioning, per button, independent:
  - 2-flop synchroniser.
  - Counter clears whenever the synced level equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the synced level and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle pulse. The release edge does nothing.
  - Latency from a stable raw press to its pulse: 2 + DEBOUNCE_CYCLES cycles (±1). A held button yields exactly one pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- State machine:
  - Actions take effect on the clk edge after the pulse cycle.
  - At most one action per cycle. Priority: edit > mem > sel > inc > dec; lower-priority pulses in the same cycle are dropped.
  - NORMAL:
    - edit -> EDIT, digit<=0, snapshot<=value.
    - mem -> MEMORY.
    - sel/inc/dec ignored.
  - EDIT:
    - sel: digit<=digit+1 mod 4 (3 wraps to 0).
    - inc: nibble[digit]<=nibble+1, 9 wraps to 0, no carry to neighbour.
    - dec: nibble[digit]<=nibble-1, 0 wraps to 9, no borrow.
    - edit: mem_value<=value, commit=1 for exactly one cycle, -> NORMAL, digit<=0.
    - mem: cancel; value<=snapshot, -> NORMAL, digit<=0, no commit.
  - MEMORY:
    - mem or edit -> NORMAL.
    - sel/inc/dec ignored.
  - mode encoding 3 is unreachable; if ever present, next state is NORMAL.
- Display mapping:
  - Registered, one cycle after value/mem_value/mode change.
  - In MEMORY, digits show mem_value; otherwise they show value.
  - Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibbles are only ever 0-9; any other nibble displays FF (blank).
- value and mem_value are never modified outside the rules above.

Test Plan:
All with DEBOUNCE_CYCLES=4.
1. Reset, then hold btn_edit 20 cycles -> exactly one transition mode 0->1 about 6 cycles after press, digit=0; release produces no further action. A 3-cycle btn_inc glitch -> no change.
2. In EDIT: inc x3, sel, dec x1, then edit -> value=16'h0093, mem_value=16'h0093, commit high exactly 1 cycle, mode=0, digit0_display=B0, digit1_display=90.
3. Wrap checks in EDIT: dec on digit0=0 -> 9; inc on 9 -> 0 with digit1 unchanged; sel x4 from 0 -> digit=0.
4. Cancel: value=0x0093, enter EDIT, inc digit0 (-> 0x0094), press mem -> value=0x0093, mode=0, commit never asserted, mem_value unchanged.
5. Simultaneous: in EDIT assert btn_inc and btn_edit pulses in the same cycle -> commit taken, no increment. In NORMAL, btn_mem -> mode=2 and displays show mem_value; btn_mem again -> mode=0.
6. Async reset mid-edit: in EDIT with digit=2 and value 0x0500, pulse rst between clk edges -> outputs at reset values immediately, all displays C0, no commit.

Source files
------------

// File: rtl/digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : digit_entry
// Purpose  : Pushbutton conditioning (sync, debounce, rising-edge pulse) and
//            4-digit BCD entry state machine feeding a multiplexed display
//            driver with mode, selected digit and active-low segment patterns.
// Revision : 1.0  initial release
// ============================================================================
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_edit,
    input  logic        btn_mem,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_dec,
    output logic [1:0]  mode,
    output logic [1:0]  digit,
    output logic [15:0] value,
    output logic [15:0] mem_value,
    output logic        commit,
    output logic [7:0]  digit0_display,
    output logic [7:0]  digit1_display,
    output logic [7:0]  digit2_display,
    output logic [7:0]  digit3_display
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_EDIT   = 2'd1,
        MODE_MEMORY = 2'd2
    } mode_t;

    // Bit order: 0=edit 1=mem 2=sel 3=inc 4=dec
    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;

    assign btn_raw = {btn_dec, btn_inc, btn_sel, btn_mem, btn_edit};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             level_q;
            logic             level_d;
            logic             level_prev_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Accept a new level only after it has differed from the current one long enough
            always_comb begin
                level_d = level_q;
                cnt_d   = '0;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Synchroniser, debounce state and previous level for edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= btn_raw[i];
                    sync2_q      <= sync1_q;
                    level_q      <= level_d;
                    level_prev_q <= level_q;
                    cnt_q        <= cnt_d;
                end
            end

            // Press edge only; release is ignored
            assign btn_pulse[i] = level_q & ~level_prev_q;
        end
    endgenerate

    mode_t       state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] value_q, value_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic [15:0] mem_q, mem_d;
    logic        commit_q, commit_d;
    logic [3:0]  nib;

    // Entry state machine: one action per cycle, edit > mem > sel > inc > dec
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        value_d    = value_q;
        snapshot_d = snapshot_q;
        mem_d      = mem_q;
        commit_d   = 1'b0;
        nib        = value_q[{digit_q, 2'b00} +: 4];
        case (state_q)
            MODE_NORMAL: begin
                if (btn_pulse[0]) begin
                    state_d    = MODE_EDIT;
                    digit_d    = 2'd0;
                    snapshot_d = value_q;
                end else if (btn_pulse[1]) begin
                    state_d = MODE_MEMORY;
                end
            end
            MODE_EDIT: begin
                if (btn_pulse[0]) begin
                    mem_d    = value_q;
                    commit_d = 1'b1;
                    state_d  = MODE_NORMAL;
                    digit_d  = 2'd0;
                end else if (btn_pulse[1]) begin
                    value_d = snapshot_q;
                    state_d = MODE_NORMAL;
                    digit_d = 2'd0;
                end else if (btn_pulse[2]) begin
                    digit_d = digit_q + 2'd1;
                end else if (btn_pulse[3]) begin
                    value_d[{digit_q, 2'b00} +: 4] = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
                end else if (btn_pulse[4]) begin
                    value_d[{digit_q, 2'b00} +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                end
            end
            MODE_MEMORY: begin
                if (btn_pulse[0] || btn_pulse[1]) begin
                    state_d = MODE_NORMAL;
                end
            end
            default: begin
                state_d = MODE_NORMAL;
            end
        endcase
    end

    // State machine registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MODE_NORMAL;
            digit_q    <= 2'd0;
            value_q    <= 16'h0000;
            snapshot_q <= 16'h0000;
            mem_q      <= 16'h0000;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            value_q    <= value_d;
            snapshot_q <= snapshot_d;
            mem_q      <= mem_d;
            commit_q   <= commit_d;
        end
    end

    // Active-low seven-segment pattern, dp off; non-BCD nibbles blank
    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    logic [15:0] disp_src;
    logic [7:0]  disp_d [4];
    logic [7:0]  disp_q [4];

    // Memory mode shows the saved value, every other mode the working value
    always_comb begin
        disp_src = (state_q == MODE_MEMORY) ? mem_q : value_q;
        for (int i = 0; i < 4; i++) begin
            disp_d[i] = seg7(disp_src[i*4 +: 4]);
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= 8'hC0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= disp_d[i];
            end
        end
    end

    assign mode           = state_q;
    assign digit          = digit_q;
    assign value          = value_q;
    assign mem_value      = mem_q;
    assign commit         = commit_q;
    assign digit0_display = disp_q[0];
    assign digit1_display = disp_q[1];
    assign digit2_display = disp_q[2];
    assign digit3_display = disp_q[3];

endmodule
`default_nettype wire

// File: tb/tb_digit_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_entry
// Purpose  : Directed self-checking bench for digit_entry with a queue of
//            expected values pushed at stimulus time and popped on checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_digit_entry;

    localparam logic [4:0] B_EDIT = 5'b00001;
    localparam logic [4:0] B_MEM  = 5'b00010;
    localparam logic [4:0] B_SEL  = 5'b00100;
    localparam logic [4:0] B_INC  = 5'b01000;
    localparam logic [4:0] B_DEC  = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [1:0]  mode;
    logic [1:0]  digit;
    logic [15:0] value;
    logic [15:0] mem_value;
    logic        commit;
    logic [7:0]  d0, d1, d2, d3;

    int checks   = 0;
    int failures = 0;
    int commit_cnt = 0;
    int commit_run = 0;
    int commit_max = 0;
    int lat;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];

    digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_edit       (btn[0]),
        .btn_mem        (btn[1]),
        .btn_sel        (btn[2]),
        .btn_inc        (btn[3]),
        .btn_dec        (btn[4]),
        .mode           (mode),
        .digit          (digit),
        .value          (value),
        .mem_value      (mem_value),
        .commit         (commit),
        .digit0_display (d0),
        .digit1_display (d1),
        .digit2_display (d2),
        .digit3_display (d3)
    );

    always #5 clk = ~clk;

    // Commit pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            commit_cnt <= commit_cnt + 1;
            commit_run <= commit_run + 1;
            if (commit_run + 1 > commit_max) commit_max <= commit_run + 1;
        end else begin
            commit_run <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic press(input logic [4:0] m);
        btn = m;
        tick(8);
        btn = 5'b0;
        tick(8);
    endtask

    initial begin
        rst = 1'b1;
        btn = 5'b0;
        tick(2);
        // Reset state
        expect_val("rst_mode", 16'd0);       check(16'(mode));
        expect_val("rst_digit", 16'd0);      check(16'(digit));
        expect_val("rst_value", 16'h0000);   check(value);
        expect_val("rst_mem", 16'h0000);     check(mem_value);
        expect_val("rst_commit", 16'd0);     check(16'(commit));
        expect_val("rst_d0", 16'h00C0);      check(16'(d0));
        expect_val("rst_d3", 16'h00C0);      check(16'(d3));
        rst = 1'b0;
        tick(2);

        // 1. Held edit press: one transition ~6 cycles in, release does nothing
        btn = B_EDIT;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (lat == 0 && mode == 2'd1) lat = k;
        end
        expect_val("press_latency_ok", 16'd1); check(16'(lat >= 5 && lat <= 8));
        expect_val("hold_mode", 16'd1);        check(16'(mode));
        expect_val("hold_digit", 16'd0);       check(16'(digit));
        btn = 5'b0;
        tick(10);
        expect_val("release_mode", 16'd1);     check(16'(mode));
        btn = B_INC;
        tick(3);
        btn = 5'b0;
        tick(10);
        expect_val("glitch_value", 16'h0000);  check(value);

        // 2. inc x3, sel, dec, commit
        press(B_INC); press(B_INC); press(B_INC);
        press(B_SEL);
        press(B_DEC);
        expect_val("edit_value", 16'h0093);    check(value);
        press(B_EDIT);
        expect_val("commit_value", 16'h0093);  check(value);
        expect_val("commit_mem", 16'h0093);    check(mem_value);
        expect_val("commit_count", 16'd1);     check(16'(commit_cnt));
        expect_val("commit_width", 16'd1);     check(16'(commit_max));
        expect_val("commit_mode", 16'd0);      check(16'(mode));
        expect_val("commit_d0", 16'h00B0);     check(16'(d0));
        expect_val("commit_d1", 16'h0090);     check(16'(d1));

        // 3. Wrap checks
        press(B_EDIT);
        press(B_DEC); press(B_DEC); press(B_DEC);
        press(B_DEC);
        expect_val("dec_wrap", 16'h0099);      check(value);
        press(B_INC);
        expect_val("inc_wrap", 16'h0090);      check(value);
        press(B_SEL); press(B_SEL); press(B_SEL);
        expect_val("sel_3", 16'd3);            check(16'(digit));
        press(B_SEL);
        expect_val("sel_wrap", 16'd0);         check(16'(digit));
        press(B_MEM);
        expect_val("wrap_cancel", 16'h0093);   check(value);

        // 4. Cancel
        press(B_EDIT);
        press(B_INC);
        expect_val("cancel_pre", 16'h0094);    check(value);
        press(B_MEM);
        expect_val("cancel_value", 16'h0093);  check(value);
        expect_val("cancel_mode", 16'd0);      check(16'(mode));
        expect_val("cancel_mem", 16'h0093);    check(mem_value);
        expect_val("cancel_commits", 16'd1);   check(16'(commit_cnt));

        // 5. Simultaneous edit+inc, then memory view
        press(B_EDIT);
        press(B_EDIT | B_INC);
        expect_val("simul_commits", 16'd2);    check(16'(commit_cnt));
        expect_val("simul_value", 16'h0093);   check(value);
        expect_val("simul_mode", 16'd0);       check(16'(mode));
        press(B_MEM);
        expect_val("memview_mode", 16'd2);     check(16'(mode));
        expect_val("memview_d0", 16'h00B0);    check(16'(d0));
        expect_val("memview_d1", 16'h0090);    check(16'(d1));
        expect_val("memview_d3", 16'h00C0);    check(16'(d3));
        press(B_MEM);
        expect_val("memview_exit", 16'd0);     check(16'(mode));

        // 6. Asynchronous reset mid-edit
        press(B_EDIT);
        press(B_DEC); press(B_DEC); press(B_DEC);
        press(B_SEL);
        press(B_INC);
        press(B_SEL);
        for (int k = 0; k < 5; k++) press(B_INC);
        expect_val("pre_rst_value", 16'h0500); check(value);
        expect_val("pre_rst_digit", 16'd2);    check(16'(digit));
        expect_val("pre_rst_mode", 16'd1);     check(16'(mode));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expect_val("arst_mode", 16'd0);        check(16'(mode));
        expect_val("arst_digit", 16'd0);       check(16'(digit));
        expect_val("arst_value", 16'h0000);    check(value);
        expect_val("arst_mem", 16'h0000);      check(mem_value);
        expect_val("arst_commit", 16'd0);      check(16'(commit));
        expect_val("arst_d0", 16'h00C0);       check(16'(d0));
        expect_val("arst_d1", 16'h00C0);       check(16'(d1));
        expect_val("arst_d2", 16'h00C0);       check(16'(d2));
        expect_val("arst_d3", 16'h00C0);       check(16'(d3));
        tick(2);
        rst = 1'b0;
        tick(4);
        expect_val("post_rst_commits", 16'd2); check(16'(commit_cnt));
        expect_val("post_rst_mem", 16'h0000);  check(mem_value);

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
